fetch_queue: RTL and testbench

- 2-wide instruction queue between the fetch unit and the two decoder lanes of the superscalar front end.
- Buffers {pc, inst} pairs coming from a 64-bit instruction-memory fetch and presents the two oldest entries to decoder lane 0 and lane 1 in program order.
- Decouples fetch from decode stalls.
- Discards all contents on a branch/jump redirect.

---
 rtl/fetch_queue.sv | 107 ++++++++++
 tb/tb_fetch_queue.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// 2-wide {pc, inst} circular queue between fetch and the two decoder lanes.
// Presents the two oldest entries in program order (first-word fall-through); redirect flushes all.
module fetch_queue #(
    parameter int DEPTH = 8,
    parameter int XLEN  = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush_i,
    input  logic [1:0]               enq_valid_i,
    input  logic [XLEN-1:0]          enq_pc_i,
    input  logic [XLEN-1:0]          enq_inst0_i,
    input  logic [XLEN-1:0]          enq_inst1_i,
    output logic                     enq_ready_o,
    output logic [1:0]               deq_valid_o,
    output logic [XLEN-1:0]          deq_pc0_o,
    output logic [XLEN-1:0]          deq_inst0_o,
    output logic [XLEN-1:0]          deq_pc1_o,
    output logic [XLEN-1:0]          deq_inst1_o,
    input  logic [1:0]               deq_ready_i,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0]   r_head;
    logic [AW-1:0]   r_tail;
    logic [CW-1:0]   r_count;
    logic [XLEN-1:0] r_pc_mem   [DEPTH];
    logic [XLEN-1:0] r_inst_mem [DEPTH];

    logic [AW-1:0]   w_head1;
    logic [AW-1:0]   w_tail1;
    logic            w_enq_ready;
    logic            w_enq_fire;
    logic [1:0]      w_push;
    logic [1:0]      w_deq_valid;
    logic [1:0]      w_deq_fire;
    logic [1:0]      w_pop;
    logic [CW-1:0]   w_count_next;
    logic [XLEN-1:0] w_pc1;

    // Ready looks only at registered occupancy, so no path from deq_ready_i.
    assign w_enq_ready = (CW'(DEPTH) - r_count) >= CW'(2);
    assign w_enq_fire  = w_enq_ready & ~flush_i;
    assign w_head1     = r_head + AW'(1);
    assign w_tail1     = r_tail + AW'(1);
    assign w_pc1       = enq_pc_i + XLEN'(4);

    always_comb begin
        w_push = 2'd0;
        if (w_enq_fire && enq_valid_i[0]) begin
            w_push = enq_valid_i[1] ? 2'd2 : 2'd1;
        end
    end

    assign w_deq_valid[0] = (r_count >= CW'(1)) & ~flush_i;
    assign w_deq_valid[1] = (r_count >= CW'(2)) & ~flush_i;
    assign w_deq_fire     = w_deq_valid & deq_ready_i;

    always_comb begin
        w_pop = 2'd0;
        if (w_deq_fire[0]) begin
            w_pop = w_deq_fire[1] ? 2'd2 : 2'd1;
        end
    end

    assign w_count_next = r_count + CW'(w_push) - CW'(w_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (flush_i) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_head  <= r_head + AW'(w_pop);
            r_tail  <= r_tail + AW'(w_push);
            r_count <= w_count_next;
        end
    end

    // Storage carries no reset; occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (w_push != 2'd0) begin
            r_pc_mem[r_tail]   <= enq_pc_i;
            r_inst_mem[r_tail] <= enq_inst0_i;
        end
        if (w_push == 2'd2) begin
            r_pc_mem[w_tail1]   <= w_pc1;
            r_inst_mem[w_tail1] <= enq_inst1_i;
        end
    end

    assign enq_ready_o = w_enq_ready;
    assign deq_valid_o = w_deq_valid;
    assign count_o     = r_count;
    assign deq_pc0_o   = w_deq_valid[0] ? r_pc_mem[r_head]    : '0;
    assign deq_inst0_o = w_deq_valid[0] ? r_inst_mem[r_head]  : '0;
    assign deq_pc1_o   = w_deq_valid[1] ? r_pc_mem[w_head1]   : '0;
    assign deq_inst1_o = w_deq_valid[1] ? r_inst_mem[w_head1] : '0;

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: vector table with hand-derived occupancy plus a queue scoreboard
// that predicts lane contents; extra sequences for sustained traffic, wrap, async reset and pc wrap.
module tb_fetch_queue;

    localparam int DEPTH = 8;
    localparam int XLEN  = 32;

    logic             clk;
    logic             rst_n;
    logic             flush_i;
    logic [1:0]       enq_valid_i;
    logic [XLEN-1:0]  enq_pc_i;
    logic [XLEN-1:0]  enq_inst0_i;
    logic [XLEN-1:0]  enq_inst1_i;
    logic             enq_ready_o;
    logic [1:0]       deq_valid_o;
    logic [XLEN-1:0]  deq_pc0_o;
    logic [XLEN-1:0]  deq_inst0_o;
    logic [XLEN-1:0]  deq_pc1_o;
    logic [XLEN-1:0]  deq_inst1_o;
    logic [1:0]       deq_ready_i;
    logic [3:0]       count_o;

    fetch_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush_i     (flush_i),
        .enq_valid_i (enq_valid_i),
        .enq_pc_i    (enq_pc_i),
        .enq_inst0_i (enq_inst0_i),
        .enq_inst1_i (enq_inst1_i),
        .enq_ready_o (enq_ready_o),
        .deq_valid_o (deq_valid_o),
        .deq_pc0_o   (deq_pc0_o),
        .deq_inst0_o (deq_inst0_o),
        .deq_pc1_o   (deq_pc1_o),
        .deq_inst1_o (deq_inst1_o),
        .deq_ready_i (deq_ready_i),
        .count_o     (count_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    typedef struct {
        logic        fl;
        logic [1:0]  ev;
        logic [31:0] pc;
        logic [31:0] i0;
        logic [31:0] i1;
        logic [1:0]  dr;
        logic [3:0]  exp_cnt;
        logic        exp_rdy;
    } vec_t;

    ent_t sb[$];
    vec_t tbl[12];
    int   n_cmp  = 0;
    int   n_fail = 0;

    always @(posedge clk) begin
        if (rst_n) begin
            assert (enq_valid_i != 2'b10 && deq_ready_i != 2'b10)
                else $error("illegal mask enq=%b deq=%b", enq_valid_i, deq_ready_i);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one cycle from just after a falling edge, check combinational outputs against
    // the scoreboard, then advance the scoreboard at the rising edge.
    task automatic step(input logic fl, input logic [1:0] ev, input logic [31:0] pc,
                        input logic [31:0] i0, input logic [31:0] i1, input logic [1:0] dr);
        int   n;
        logic [1:0] v;
        logic rdy;
        int   npop;
        ent_t e;
        flush_i     = fl;
        enq_valid_i = ev;
        enq_pc_i    = pc;
        enq_inst0_i = i0;
        enq_inst1_i = i1;
        deq_ready_i = dr;
        #1;
        n   = sb.size();
        rdy = ((DEPTH - n) >= 2);
        v   = fl ? 2'b00 : (n >= 2 ? 2'b11 : (n >= 1 ? 2'b01 : 2'b00));
        chk("count", 64'(count_o), 64'(n));
        chk("enq_ready", 64'(enq_ready_o), 64'(rdy));
        chk("deq_valid", 64'(deq_valid_o), 64'(v));
        chk("lane0_pc",   64'(deq_pc0_o),   v[0] ? 64'(sb[0].pc)   : 64'd0);
        chk("lane0_inst", 64'(deq_inst0_o), v[0] ? 64'(sb[0].inst) : 64'd0);
        chk("lane1_pc",   64'(deq_pc1_o),   v[1] ? 64'(sb[1].pc)   : 64'd0);
        chk("lane1_inst", 64'(deq_inst1_o), v[1] ? 64'(sb[1].inst) : 64'd0);
        npop = int'(v[0] & dr[0]) + int'(v[1] & dr[1]);
        @(posedge clk);
        if (fl) begin
            sb.delete();
        end else begin
            for (int k = 0; k < npop; k++) e = sb.pop_front();
            if (rdy && ev[0]) begin
                e.pc = pc; e.inst = i0; sb.push_back(e);
                if (ev[1]) begin
                    e.pc = pc + 32'd4; e.inst = i1; sb.push_back(e);
                end
            end
        end
        @(negedge clk);
    endtask

    function automatic logic [31:0] ia(input logic [31:0] pc);
        return pc ^ 32'hA5A5_0013;
    endfunction

    function automatic logic [31:0] ib(input logic [31:0] pc);
        return ~pc;
    endfunction

    initial begin
        rst_n       = 1'b0;
        flush_i     = 1'b0;
        enq_valid_i = 2'b00;
        enq_pc_i    = '0;
        enq_inst0_i = '0;
        enq_inst1_i = '0;
        deq_ready_i = 2'b00;
        #2;
        chk("rst_count", 64'(count_o), 64'd0);
        chk("rst_valid", 64'(deq_valid_o), 64'd0);
        chk("rst_ready", 64'(enq_ready_o), 64'd1);
        chk("rst_data", {deq_pc0_o | deq_pc1_o, deq_inst0_o | deq_inst1_o}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        tbl[0]  = '{1'b0, 2'b11, 32'h1000, 32'h0050_0093, 32'h00A0_0113, 2'b00, 4'd2, 1'b1};
        tbl[1]  = '{1'b0, 2'b11, 32'h1008, ia(32'h1008), ib(32'h1008), 2'b00, 4'd4, 1'b1};
        tbl[2]  = '{1'b0, 2'b11, 32'h1010, ia(32'h1010), ib(32'h1010), 2'b00, 4'd6, 1'b1};
        tbl[3]  = '{1'b0, 2'b11, 32'h1018, ia(32'h1018), ib(32'h1018), 2'b00, 4'd8, 1'b0};
        tbl[4]  = '{1'b0, 2'b11, 32'h1020, ia(32'h1020), ib(32'h1020), 2'b00, 4'd8, 1'b0};
        tbl[5]  = '{1'b0, 2'b11, 32'h1028, ia(32'h1028), ib(32'h1028), 2'b11, 4'd6, 1'b1};
        tbl[6]  = '{1'b0, 2'b00, 32'h0,    32'h0,        32'h0,        2'b11, 4'd4, 1'b1};
        tbl[7]  = '{1'b0, 2'b00, 32'h0,    32'h0,        32'h0,        2'b01, 4'd3, 1'b1};
        tbl[8]  = '{1'b0, 2'b00, 32'h0,    32'h0,        32'h0,        2'b01, 4'd2, 1'b1};
        tbl[9]  = '{1'b0, 2'b11, 32'h1030, ia(32'h1030), ib(32'h1030), 2'b00, 4'd4, 1'b1};
        tbl[10] = '{1'b0, 2'b01, 32'h1038, ia(32'h1038), ib(32'h1038), 2'b00, 4'd5, 1'b1};
        tbl[11] = '{1'b1, 2'b11, 32'h1040, ia(32'h1040), ib(32'h1040), 2'b11, 4'd0, 1'b1};

        for (int i = 0; i < 12; i++) begin
            step(tbl[i].fl, tbl[i].ev, tbl[i].pc, tbl[i].i0, tbl[i].i1, tbl[i].dr);
            chk($sformatf("vec%0d_count", i), 64'(count_o), 64'(tbl[i].exp_cnt));
            chk($sformatf("vec%0d_ready", i), 64'(enq_ready_o), 64'(tbl[i].exp_rdy));
            if (i == 0) begin
                chk("first_pc0",   64'(deq_pc0_o),   64'h1000);
                chk("first_inst0", 64'(deq_inst0_o), 64'h0050_0093);
                chk("first_pc1",   64'(deq_pc1_o),   64'h1004);
                chk("first_inst1", 64'(deq_inst1_o), 64'h00A0_0113);
                chk("first_valid", 64'(deq_valid_o), 64'd3);
            end
            if (i == 4) chk("full_oldest_pc", 64'(deq_pc0_o), 64'h1000);
            if (i == 8) chk("single_lane_shift", 64'(deq_pc0_o), 64'h1018);
            if (i == 10) begin
                flush_i = 1'b1;
                #1;
                chk("flush_same_cycle_valid", 64'(deq_valid_o), 64'd0);
                flush_i = 1'b0;
            end
        end

        for (int k = 0; k < 20; k++) begin
            step(1'b0, 2'b11, 32'h2000 + 32'(8 * k), ia(32'h2000 + 32'(8 * k)),
                 ib(32'h2000 + 32'(8 * k)), 2'b11);
            chk("sustain_count", 64'(count_o), 64'd2);
            chk("sustain_pc0", 64'(deq_pc0_o), 64'(32'h2000 + 32'(8 * k)));
        end

        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_count", 64'(count_o), 64'd0);
        chk("async_rst_valid", 64'(deq_valid_o), 64'd0);
        chk("async_rst_ready", 64'(enq_ready_o), 64'd1);
        chk("async_rst_data", {deq_pc0_o | deq_pc1_o, deq_inst0_o | deq_inst1_o}, 64'd0);
        sb.delete();
        enq_valid_i = 2'b00;
        deq_ready_i = 2'b00;
        @(negedge clk);
        rst_n = 1'b1;

        step(1'b0, 2'b01, 32'h3000, ia(32'h3000), ib(32'h3000), 2'b00);
        for (int k = 0; k < 6; k++) begin
            step(1'b0, 2'b11, 32'h3004 + 32'(8 * k), ia(32'h3004 + 32'(8 * k)),
                 ib(32'h3004 + 32'(8 * k)), 2'b11);
            chk("odd_wrap_count", 64'(count_o), 64'd2);
        end
        step(1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 2'b11);
        chk("drain_count", 64'(count_o), 64'd0);

        step(1'b0, 2'b11, 32'hFFFF_FFFC, 32'h1111_1111, 32'h2222_2222, 2'b00);
        chk("pcwrap_pc0", 64'(deq_pc0_o), 64'hFFFF_FFFC);
        chk("pcwrap_pc1", 64'(deq_pc1_o), 64'h0);
        chk("pcwrap_inst1", 64'(deq_inst1_o), 64'h2222_2222);
        step(1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 2'b11);
        step(1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 2'b00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
